// File: rtl/triangle_assembler.sv
// Gathers three consecutive vertices into a triangle record and queues it in a FWFT FIFO.
// Define TRI_DEGEN_CULL_EN to drop triangles with any two bit-identical vertices.
module triangle_assembler #(
  parameter int DEPTH = 4,
  parameter int VW    = 48,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [VW-1:0] vertex,
  input  logic [CW-1:0] color,
  input  logic          new_triangle,
  input  logic          vertex_valid,
  input  logic          done_in,
  output logic          in_ready,
  output logic [VW-1:0] tri_v0,
  output logic [VW-1:0] tri_v1,
  output logic [VW-1:0] tri_v2,
  output logic [CW-1:0] tri_color,
  output logic          tri_valid,
  input  logic          tri_ready,
  output logic          frame_done,
  output logic          malformed
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    logic [CW-1:0] color;
  } tri_t;

  typedef enum logic [1:0] {S_V0, S_V1, S_V2} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] v0_q, v1_q;
  logic [CW-1:0] color_q;
  logic          ld_v0, ld_v1, push, pop, bad, accept, degen, pending;
  tri_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;

  assign in_ready   = (count != CNTW'(DEPTH));
  assign accept     = vertex_valid && in_ready;
  assign tri_valid  = (count != '0);
  assign pop        = tri_valid && tri_ready;
  assign frame_done = pending && (count == '0) && (state == S_V0);
  assign tri_v0     = mem[rd_ptr].v0;
  assign tri_v1     = mem[rd_ptr].v1;
  assign tri_v2     = mem[rd_ptr].v2;
  assign tri_color  = mem[rd_ptr].color;

`ifdef TRI_DEGEN_CULL_EN
  assign degen = (v0_q == v1_q) || (v0_q == vertex) || (v1_q == vertex);
`else
  assign degen = 1'b0;
`endif

  // A new_triangle in V1/V2 restarts collection with this vertex as v0.
  always_comb begin
    state_nxt = state;
    ld_v0     = 1'b0;
    ld_v1     = 1'b0;
    push      = 1'b0;
    bad       = 1'b0;
    if (accept) begin
      case (state)
        S_V0: if (new_triangle) begin ld_v0 = 1'b1; state_nxt = S_V1; end
              else bad = 1'b1;
        S_V1: if (new_triangle) begin ld_v0 = 1'b1; bad = 1'b1; end
              else begin ld_v1 = 1'b1; state_nxt = S_V2; end
        S_V2: if (new_triangle) begin ld_v0 = 1'b1; bad = 1'b1; state_nxt = S_V1; end
              else begin push = !degen; state_nxt = S_V0; end
        default: state_nxt = S_V0;
      endcase
    end
    // done_in discards whatever partial triangle remains after this cycle's vertex.
    if (done_in && state_nxt != S_V0) begin
      bad       = 1'b1;
      state_nxt = S_V0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_V0;
      v0_q      <= '0;
      v1_q      <= '0;
      color_q   <= '0;
      malformed <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      malformed <= bad;
      if (ld_v0) begin
        v0_q    <= vertex;
        color_q <= color;
      end
      if (ld_v1) v1_q <= vertex;
      // A done_in coinciding with frame_done is absorbed into the current frame.
      if (frame_done)   pending <= 1'b0;
      else if (done_in) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{v0: v0_q, v1: v1_q, v2: vertex, color: color_q};
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
